// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer: alignment check, memory read into the MDR,
// read-modify-write for sub-word stores, and the size-select code for the size mux.
module mem_access_ctrl #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [1:0]  size,
  input  logic [31:0] addr_in,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] merged_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mdr,
  output logic [2:0]  size_sel,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [3:0] LAT      = 4'(MEM_LATENCY);
  localparam logic [2:0] SEL_NONE = 3'b110;

  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] mdr_q, mdr_d;
  logic [2:0]  sel_q, sel_d;
  logic        mis_q, mis_d;

  logic        fault;
  logic        sub_word;

  function automatic logic [2:0] size_code(input logic is_store, input logic [1:0] sz);
    logic [2:0] code;
    unique case (sz)
      2'b00:   code = is_store ? 3'b000 : 3'b011;
      2'b01:   code = is_store ? 3'b010 : 3'b101;
      default: code = is_store ? 3'b001 : 3'b100;
    endcase
    return code;
  endfunction

  assign sub_word = (size == 2'b00) || (size == 2'b01);
  assign fault    = ((size == 2'b01) && addr_in[0]) ||
                    (size[1] && (addr_in[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mdr_d   = mdr_q;
    sel_d   = sel_q;
    mis_d   = mis_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          addr_d = addr_in;
          sel_d  = size_code(op, size);
          if (fault) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else if (!op || sub_word) begin
            cnt_d   = LAT;
            state_d = RD;
          end else begin
            state_d = WR;
          end
        end
      end
      RD: begin
        // Last latency cycle: capture read data, then finish a load or merge a store.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          mdr_d   = mem_rdata;
          state_d = op_q ? WR : DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR:   state_d = DONE;
      DONE: begin
        mis_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      mdr_q   <= 32'd0;
      sel_q   <= SEL_NONE;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mdr_q   <= mdr_d;
      sel_q   <= sel_d;
      mis_q   <= mis_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wr     = (state_q == WR);
  assign mem_wdata  = merged_wdata;
  assign mdr        = mdr_q;
  assign size_sel   = sel_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign misaligned = mis_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (latency 1 and 3) checked every cycle
// against a timeline model of each command, plus directed literal checks.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [1:0]  size;
  logic [31:0] addr_in, rdata, wdata_in;

  logic [31:0] mem_addr_o [2];
  logic        mem_wr_o   [2];
  logic [31:0] mem_wdata_o[2];
  logic [31:0] mdr_o      [2];
  logic [2:0]  size_sel_o [2];
  logic        busy_o     [2];
  logic        done_o     [2];
  logic        mis_o      [2];

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LATENCY(1)) u0 (
    .clk(clk), .reset(rst), .start(start), .op(op), .size(size), .addr_in(addr_in),
    .mem_rdata(rdata), .merged_wdata(wdata_in),
    .mem_addr(mem_addr_o[0]), .mem_wr(mem_wr_o[0]), .mem_wdata(mem_wdata_o[0]),
    .mdr(mdr_o[0]), .size_sel(size_sel_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .misaligned(mis_o[0]));

  mem_access_ctrl #(.MEM_LATENCY(3)) u1 (
    .clk(clk), .reset(rst), .start(start), .op(op), .size(size), .addr_in(addr_in),
    .mem_rdata(rdata), .merged_wdata(wdata_in),
    .mem_addr(mem_addr_o[1]), .mem_wr(mem_wr_o[1]), .mem_wdata(mem_wdata_o[1]),
    .mdr(mdr_o[1]), .size_sel(size_sel_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .misaligned(mis_o[1]));

  // Model: each accepted command is a timeline of mtot cycles; mk counts the cycle (0 = idle).
  int          lat  [2] = '{1, 3};
  int          mk   [2];
  int          mtot [2];
  bit          mfault[2], mop[2], mreads[2];
  logic [31:0] maddr[2], mmdr[2];
  logic [2:0]  msel [2];

  function automatic logic [2:0] exp_sel(input bit st, input logic [1:0] sz);
    if (sz == 2'd0) return st ? 3'd0 : 3'd3;
    if (sz == 2'd1) return st ? 3'd2 : 3'd5;
    return st ? 3'd1 : 3'd4;
  endfunction

  task automatic model_edge(input int i);
    if (rst) begin
      mk[i] = 0; mfault[i] = 0; maddr[i] = 0; mmdr[i] = 0; msel[i] = 3'b110;
    end else if (mk[i] == 0) begin
      if (start) begin
        maddr[i]  = addr_in;
        msel[i]   = exp_sel(op, size);
        mop[i]    = op;
        mfault[i] = (size == 2'd1 && addr_in[0]) || (size[1] && addr_in[1:0] != 2'd0);
        mreads[i] = !mfault[i] && (!op || size < 2'd2);
        if (mfault[i])      mtot[i] = 1;
        else if (!op)       mtot[i] = lat[i] + 1;
        else if (mreads[i]) mtot[i] = lat[i] + 2;
        else                mtot[i] = 2;
        mk[i] = 1;
      end
    end else begin
      if (mreads[i] && mk[i] == lat[i]) mmdr[i] = rdata;
      mk[i] = (mk[i] == mtot[i]) ? 0 : mk[i] + 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare(input int i);
    bit e_busy, e_done, e_wr;
    e_busy = (mk[i] != 0);
    e_done = e_busy && (mk[i] == mtot[i]);
    e_wr   = e_busy && mop[i] && !mfault[i] && (mk[i] == mtot[i] - 1);
    chk($sformatf("busy%0d", i),     32'(busy_o[i]),     32'(e_busy));
    chk($sformatf("done%0d", i),     32'(done_o[i]),     32'(e_done));
    chk($sformatf("mem_wr%0d", i),   32'(mem_wr_o[i]),   32'(e_wr));
    chk($sformatf("misalign%0d", i), 32'(mis_o[i]),      32'(e_done && mfault[i]));
    chk($sformatf("mem_addr%0d", i), mem_addr_o[i],      maddr[i]);
    chk($sformatf("size_sel%0d", i), 32'(size_sel_o[i]), 32'(msel[i]));
    chk($sformatf("mdr%0d", i),      mdr_o[i],           mmdr[i]);
    if (e_wr) chk($sformatf("mem_wdata%0d", i), mem_wdata_o[i], wdata_in);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    compare(0);
    compare(1);
  endtask

  task automatic cmd(input bit o, input logic [1:0] s, input logic [31:0] a);
    start = 1; op = o; size = s; addr_in = a;
    tick();
    start = 0;
  endtask

  initial begin
    rst = 1; start = 1; op = 0; size = 0; addr_in = 32'h1234; rdata = 0; wdata_in = 0;
    for (int i = 0; i < 2; i++) begin
      mk[i] = 0; mtot[i] = 1; mfault[i] = 0; mop[i] = 0; mreads[i] = 0;
      maddr[i] = 0; mmdr[i] = 0; msel[i] = 3'b110;
    end
    @(negedge clk);
    tick();
    chk("rst_busy", 32'(busy_o[0]), 32'd0);
    chk("rst_sel",  32'(size_sel_o[1]), 32'b110);
    chk("rst_addr", mem_addr_o[0], 32'd0);
    rst = 0; start = 0;
    tick();

    // Word load, latency 1
    rdata = 32'hAABBCCDD;
    cmd(0, 2'd2, 32'h10);
    chk("wl_busy1", 32'(busy_o[0]), 32'd1);
    chk("wl_sel",   32'(size_sel_o[0]), 32'b100);
    tick();
    chk("wl_done2", 32'(done_o[0]), 32'd1);
    chk("wl_mdr",   mdr_o[0], 32'hAABBCCDD);
    repeat (4) tick();

    // Byte store, latency 3, with a stray start during RD
    wdata_in = 32'h11223344;
    cmd(1, 2'd0, 32'h13);
    chk("bs_sel", 32'(size_sel_o[1]), 32'b000);
    start = 1; op = 0; size = 2'd2; addr_in = 32'h40;
    tick();
    start = 0;
    tick();
    chk("bs_nowr3", 32'(mem_wr_o[1]), 32'd0);
    tick();
    chk("bs_wr4",    32'(mem_wr_o[1]), 32'd1);
    chk("bs_wdata4", mem_wdata_o[1], 32'h11223344);
    chk("bs_addr4",  mem_addr_o[1], 32'h13);
    tick();
    chk("bs_done5", 32'(done_o[1]), 32'd1);
    tick();

    // Word store
    cmd(1, 2'd2, 32'h20);
    chk("ws_wr1",  32'(mem_wr_o[0]), 32'd1);
    chk("ws_sel",  32'(size_sel_o[0]), 32'b001);
    tick();
    chk("ws_done2", 32'(done_o[1]), 32'd1);
    tick();

    // Misaligned half load and word store
    cmd(0, 2'd1, 32'h21);
    chk("mh_done", 32'(done_o[0]), 32'd1);
    chk("mh_mis",  32'(mis_o[1]), 32'd1);
    tick();
    cmd(1, 2'd2, 32'h22);
    chk("mw_mis", 32'(mis_o[0]), 32'd1);
    chk("mw_wr",  32'(mem_wr_o[1]), 32'd0);
    tick();

    // Reset during WR
    cmd(1, 2'd3, 32'h30);
    rst = 1;
    tick();
    chk("rw_wr",   32'(mem_wr_o[0]), 32'd0);
    chk("rw_done", 32'(done_o[0]), 32'd0);
    chk("rw_busy", 32'(busy_o[0]), 32'd0);
    rst = 0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 99) < 2);
      start    = ($urandom_range(0, 99) < 40);
      op       = 1'($urandom);
      size     = 2'($urandom);
      addr_in  = $urandom;
      rdata    = $urandom;
      wdata_in = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multicycle memory-access sequencer between the control unit and the memory/size-handling datapath.
- Accepts one load/store command at a time and checks alignment.
- Drives the memory address and write strobe, and owns the memory data register (MDR) that feeds the size-handling mux's memory-word input.
- Sequences the read-modify-write needed by sub-word stores, and drives the 3-bit size-select code consumed by the size-handling mux.

Parameters:
- MEM_LATENCY, 1: cycles from mem_addr valid to mem_rdata valid; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; forces all state/outputs to reset values at next edge
- start  in  1  command strobe; sampled only in IDLE
- op  in  1  0 = load, 1 = store
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- addr_in  in  32  byte address of access
- mem_rdata  in  32  memory read data
- merged_wdata  in  32  store word returned by size-handling mux (built from mdr and register B)
- mem_addr  out  32  registered memory address
- mem_wr  out  1  memory write strobe
- mem_wdata  out  32  equals merged_wdata (combinational pass-through, qualified by mem_wr)
- mdr  out  32  memory data register; feeds size-handling mux memory input
- size_sel  out  3  code to size-handling mux: sb 000, sw 001, sh 010, lb 011, lw 100, lh 101
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- misaligned  out  1  valid with done; 1 = access aborted

Behaviour:
- Reset values:
  - mem_addr = 0, mem_wr = 0, mdr = 0, size_sel = 110 (mux default, zero output).
  - busy = 0, done = 0, misaligned = 0.
  - State IDLE, latency counter = 0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - When start = 1: latch op, size and addr_in into mem_addr; latch size_sel from (op, size).
  - Alignment fault: half with addr[0] = 1, or word with addr[1:0] != 00.
  - Fault -> DONE with misaligned = 1; mdr unchanged; no memory write.
  - Otherwise: load or sub-word store -> RD, counter = MEM_LATENCY; word store -> WR.
- RD:
  - mem_wr = 0.
  - Counter decrements each cycle; on the edge where the counter equals 1, mdr <= mem_rdata.
  - RD lasts exactly MEM_LATENCY cycles, then: load -> DONE; sub-word store -> WR.
- WR:
  - Exactly one cycle with mem_wr = 1 and mem_wdata = merged_wdata.
  - mem_addr and size_sel held stable. Then -> DONE.
- DONE:
  - done = 1 for one cycle; misaligned = 1 only if the alignment fault occurred.
  - Then -> IDLE; misaligned clears to 0 on leaving DONE.
- size_sel and mem_addr are held from the latch edge until the next accepted command. They do not revert in IDLE, so mdr-based load results remain valid after done.
- Latency after the start edge:
  - load: done in cycle MEM_LATENCY+1
  - sub-word store: write in cycle MEM_LATENCY+1, done in MEM_LATENCY+2
  - word store: write in cycle 1, done in cycle 2
  - fault: done in cycle 1
- start while busy: ignored, not queued.
- start in the same cycle as done: ignored; the next command is accepted only in IDLE.
- reset mid-operation, including during WR: the next edge returns to IDLE with reset values. A write already in progress is cut to that single cycle; no further write is issued.
- Simultaneous reset and start: reset wins.
- Word store never reads memory; mdr is unchanged.

Test Plan:
- Reset: assert reset with start = 1 -> after the edge all outputs at reset values, busy = 0, size_sel = 110.
- Word load: MEM_LATENCY = 1, addr 0x00000010, mem_rdata = 0xAABBCCDD.
  - busy cycles 1–2; size_sel = 100; mdr = 0xAABBCCDD at the cycle-2 done pulse; mem_wr never asserted.
- Byte store: addr 0x00000013, MEM_LATENCY = 3, merged_wdata = 0x11223344.
  - RD for 3 cycles; size_sel = 000.
  - mem_wr = 1 in cycle 4 only, with mem_wdata 0x11223344 and mem_addr 0x13; done in cycle 5.
- Word store: addr 0x00000020 -> mem_wr in cycle 1 only; done cycle 2; size_sel = 001; mdr unchanged.
- Misaligned: half load at 0x00000021 -> done = 1 with misaligned = 1 in cycle 1; no RD, no write. Word store at 0x00000022 -> same.
- Robustness: start pulsed during RD -> ignored. Reset asserted in WR -> mem_wr = 0 next cycle, state IDLE, no done pulse.
